// File: rtl/wb_forward_pipe.sv
// Write-back pipeline (MEM and WB registers) that produces the EX/MEM/WB forwarding
// buses, the register-file write port and the load-use stall request.
module wb_forward_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ex_valid,
  input  logic                       ex_rf_we,
  input  logic [REG_AW-1:0]          ex_rf_waddr,
  input  logic [DATA_W-1:0]          ex_result,
  input  logic                       ex_is_load,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [REG_AW-1:0]          id_raddr1,
  input  logic [REG_AW-1:0]          id_raddr2,
  output logic [REG_AW+DATA_W:0]     ex_to_id_bus,
  output logic [REG_AW+DATA_W:0]     mem_to_id_bus,
  output logic [REG_AW+DATA_W:0]     wb_to_id_bus,
  output logic                       rf_we,
  output logic [REG_AW-1:0]          rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  output logic                       load_use_stall
);

  localparam int unsigned BUS_W = 1 + REG_AW + DATA_W;

  logic              m_valid;
  logic              m_we;
  logic [REG_AW-1:0] m_waddr;
  logic [DATA_W-1:0] m_result;
  logic              m_is_load;

  logic              w_valid;
  logic              w_we;
  logic [REG_AW-1:0] w_waddr;
  logic [DATA_W-1:0] w_data;

  logic              ex_we_eff;
  logic              m_we_eff;
  logic              w_we_eff;
  logic [DATA_W-1:0] m_final;
  logic              ex_hit;

  // MEM register: flush clears it even while the rest of the pipe is stalled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid   <= 1'b0;
      m_we      <= 1'b0;
      m_waddr   <= '0;
      m_result  <= '0;
      m_is_load <= 1'b0;
    end else if (flush && stall) begin
      m_valid   <= 1'b0;
      m_we      <= 1'b0;
      m_waddr   <= '0;
      m_result  <= '0;
      m_is_load <= 1'b0;
    end else if (!stall) begin
      m_valid   <= ex_valid & ~flush;
      m_we      <= ex_rf_we;
      m_waddr   <= ex_rf_waddr;
      m_result  <= ex_result;
      m_is_load <= ex_is_load;
    end
  end

  // WB register captures the resolved MEM value (load data or ALU result)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_valid <= 1'b0;
      w_we    <= 1'b0;
      w_waddr <= '0;
      w_data  <= '0;
    end else if (!stall) begin
      w_valid <= m_valid;
      w_we    <= m_we;
      w_waddr <= m_waddr;
      w_data  <= m_final;
    end
  end

  always_comb begin
    ex_we_eff = resetn & ex_valid & ex_rf_we & ~ex_is_load & (ex_rf_waddr != '0);
    m_we_eff  = m_valid & m_we & (m_waddr != '0);
    w_we_eff  = w_valid & w_we & (w_waddr != '0);
    m_final   = m_is_load ? mem_rdata : m_result;
    ex_hit    = (id_raddr1 == ex_rf_waddr) | (id_raddr2 == ex_rf_waddr);
  end

  // EX bus is forced quiet in reset so garbage inputs never look like a producer
  assign ex_to_id_bus   = resetn ? {ex_we_eff, ex_rf_waddr, ex_result} : BUS_W'(0);
  assign mem_to_id_bus  = {m_we_eff, m_waddr, m_final};
  assign wb_to_id_bus   = {w_we_eff, w_waddr, w_data};

  assign rf_we    = w_we_eff;
  assign rf_waddr = w_waddr;
  assign rf_wdata = w_data;

  assign load_use_stall = resetn & ex_valid & ex_is_load & ex_rf_we &
                          (ex_rf_waddr != '0) & ex_hit;

endmodule

// File: tb/tb_wb_forward_pipe.sv
// Randomized and directed bench for wb_forward_pipe against a per-stage instruction model.
module tb_wb_forward_pipe;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid, ex_rf_we, ex_is_load, stall, flush;
  logic [4:0]  ex_rf_waddr, id_raddr1, id_raddr2;
  logic [31:0] ex_result, mem_rdata;
  logic [37:0] ex_to_id_bus, mem_to_id_bus, wb_to_id_bus;
  logic        rf_we, load_use_stall;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  wb_forward_pipe #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .resetn(resetn),
    .ex_valid(ex_valid), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .ex_result(ex_result), .ex_is_load(ex_is_load), .mem_rdata(mem_rdata),
    .stall(stall), .flush(flush), .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
    .ex_to_id_bus(ex_to_id_bus), .mem_to_id_bus(mem_to_id_bus), .wb_to_id_bus(wb_to_id_bus),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .load_use_stall(load_use_stall)
  );

  // One instruction as it sits in a pipeline stage
  typedef struct packed {
    logic        valid;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] data;
    logic        is_load;
  } instr_t;

  instr_t in_mem, in_wb;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [37:0] held_mem_bus;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic writes(input instr_t i);
    return i.valid & i.rf_we & (i.waddr != 5'd0);
  endfunction

  task automatic check_model();
    logic [31:0] mem_val;
    logic [37:0] e_ex;
    logic        e_lus;
    if (!resetn) begin
      in_mem = '0;
      in_wb  = '0;
    end
    mem_val = in_mem.is_load ? mem_rdata : in_mem.data;
    if (!resetn) begin
      e_ex  = 38'd0;
      e_lus = 1'b0;
    end else begin
      e_ex  = {ex_valid & ex_rf_we & ~ex_is_load & (ex_rf_waddr != 5'd0), ex_rf_waddr, ex_result};
      e_lus = ex_valid & ex_is_load & ex_rf_we & (ex_rf_waddr != 5'd0) &
              ((id_raddr1 == ex_rf_waddr) || (id_raddr2 == ex_rf_waddr));
    end
    check_eq("ex_bus",  64'(ex_to_id_bus),  64'(e_ex));
    check_eq("mem_bus", 64'(mem_to_id_bus), 64'({writes(in_mem), in_mem.waddr, mem_val}));
    check_eq("wb_bus",  64'(wb_to_id_bus),  64'({writes(in_wb), in_wb.waddr, in_wb.data}));
    check_eq("rf_we",    64'(rf_we),    64'(writes(in_wb)));
    check_eq("rf_waddr", 64'(rf_waddr), 64'(in_wb.waddr));
    check_eq("rf_wdata", 64'(rf_wdata), 64'(in_wb.data));
    check_eq("lus",      64'(load_use_stall), 64'(e_lus));
  endtask

  task automatic chk_cycle();
    @(negedge clk);
    check_model();
  endtask

  // Advance the model across the rising edge using the inputs held at that edge
  task automatic adv();
    instr_t nm, nw;
    @(posedge clk);
    nm = in_mem;
    nw = in_wb;
    if (!resetn) begin
      nm = '0;
      nw = '0;
    end else begin
      if (!stall) begin
        nw = in_mem;
        nw.data = in_mem.is_load ? mem_rdata : in_mem.data;
        nw.is_load = 1'b0;
      end
      if (flush && stall) nm = '0;
      else if (!stall) nm = '{ex_valid & ~flush, ex_rf_we, ex_rf_waddr, ex_result, ex_is_load};
    end
    in_mem = nm;
    in_wb  = nw;
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; ex_rf_we = 0; ex_rf_waddr = 0; ex_result = 0; ex_is_load = 0;
    stall = 0; flush = 0; id_raddr1 = 0; id_raddr2 = 0; mem_rdata = 0;
  endtask

  task automatic ex_write(input logic [4:0] a, input logic [31:0] d, input logic ld);
    ex_valid = 1; ex_rf_we = 1; ex_rf_waddr = a; ex_result = d; ex_is_load = ld;
  endtask

  task automatic rand_inputs();
    ex_valid    = ($urandom_range(0, 3) != 0);
    ex_rf_we    = ($urandom_range(0, 4) != 0);
    ex_rf_waddr = 5'($urandom_range(0, 7));
    ex_result   = $urandom;
    ex_is_load  = ($urandom_range(0, 2) == 0);
    mem_rdata   = $urandom;
    stall       = ($urandom_range(0, 4) == 0);
    flush       = ($urandom_range(0, 9) == 0);
    id_raddr1   = 5'($urandom_range(0, 7));
    id_raddr2   = 5'($urandom_range(0, 7));
  endtask

  initial begin
    in_mem = '0;
    in_wb  = '0;
    // Reset with garbage on every input
    resetn = 0;
    rand_inputs();
    ex_valid = 1; ex_rf_we = 1; ex_is_load = 1; ex_rf_waddr = 5'd4; id_raddr1 = 5'd4;
    #3;
    check_eq("rst_ex_bus",  64'(ex_to_id_bus), 64'd0);
    check_eq("rst_mem_bus", 64'(mem_to_id_bus), 64'd0);
    check_eq("rst_wb_bus",  64'(wb_to_id_bus), 64'd0);
    check_eq("rst_rf_we",   64'(rf_we), 64'd0);
    check_eq("rst_lus",     64'(load_use_stall), 64'd0);
    chk_cycle(); adv();
    chk_cycle(); adv();
    resetn = 1;
    idle();
    for (int i = 0; i < 3; i++) begin
      chk_cycle();
      check_eq("post_rst_rf_we", 64'(rf_we), 64'd0);
      adv();
    end

    // ALU chain r5 = 0x1234
    ex_write(5'd5, 32'h1234, 1'b0);
    chk_cycle();
    check_eq("alu_ex", 64'(ex_to_id_bus), 64'({1'b1, 5'd5, 32'h1234}));
    adv(); idle();
    chk_cycle();
    check_eq("alu_mem", 64'(mem_to_id_bus), 64'({1'b1, 5'd5, 32'h1234}));
    adv();
    chk_cycle();
    check_eq("alu_wb", 64'({rf_we, rf_waddr, rf_wdata}), 64'({1'b1, 5'd5, 32'h1234}));
    adv();

    // Load-use on r8
    ex_write(5'd8, 32'h0000_0100, 1'b1);
    id_raddr2 = 5'd8;
    chk_cycle();
    check_eq("lu_stall", 64'(load_use_stall), 64'd1);
    check_eq("lu_ex_we", 64'(ex_to_id_bus[37]), 64'd0);
    adv(); idle();
    mem_rdata = 32'hCAFE;
    chk_cycle();
    check_eq("lu_mem", 64'(mem_to_id_bus), 64'({1'b1, 5'd8, 32'hCAFE}));
    adv();
    mem_rdata = $urandom;
    chk_cycle();
    check_eq("lu_wdata", 64'(rf_wdata), 64'(32'hCAFE));
    adv();

    // Writes to r0 never appear
    idle();
    ex_write(5'd0, 32'hFFFF, 1'b0);
    chk_cycle();
    check_eq("r0_ex_we", 64'(ex_to_id_bus[37]), 64'd0);
    adv(); idle();
    chk_cycle();
    check_eq("r0_mem_we", 64'(mem_to_id_bus[37]), 64'd0);
    adv();
    chk_cycle();
    check_eq("r0_rf_we", 64'(rf_we), 64'd0);
    adv();
    ex_write(5'd0, 32'h55, 1'b1);
    id_raddr1 = 5'd0;
    chk_cycle();
    check_eq("r0_lus", 64'(load_use_stall), 64'd0);
    adv(); idle();

    // Stall hold with r3 = 7 in WB
    ex_write(5'd3, 32'd7, 1'b0);
    adv(); idle();
    adv();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      ex_write(5'($urandom_range(1, 31)), $urandom, 1'b0);
      chk_cycle();
      if (i == 0) held_mem_bus = mem_to_id_bus;
      else check_eq("stall_mem_hold", 64'(mem_to_id_bus), 64'(held_mem_bus));
      check_eq("stall_rf", 64'({rf_we, rf_waddr, rf_wdata}), 64'({1'b1, 5'd3, 32'd7}));
      adv();
    end
    idle();

    // Flush kills the instruction entering MEM
    ex_write(5'd9, 32'h99, 1'b0);
    flush = 1;
    chk_cycle(); adv(); idle();
    chk_cycle();
    check_eq("flush_mem_we", 64'(mem_to_id_bus[37]), 64'd0);
    adv();
    chk_cycle();
    check_eq("flush_rf_we", 64'(rf_we), 64'd0);
    adv();

    // Reset pulsed while MEM and WB hold valid writes
    ex_write(5'd10, 32'hA0, 1'b0);
    adv();
    ex_write(5'd11, 32'hB0, 1'b0);
    adv(); idle();
    resetn = 0;
    #1;
    check_eq("midrst_rf_we",   64'(rf_we), 64'd0);
    check_eq("midrst_mem_bus", 64'(mem_to_id_bus), 64'd0);
    check_eq("midrst_wb_bus",  64'(wb_to_id_bus), 64'd0);
    chk_cycle(); adv();
    resetn = 1;
    for (int i = 0; i < 2; i++) begin
      chk_cycle();
      check_eq("midrst_no_write", 64'(rf_we), 64'd0);
      adv();
    end

    // Random traffic with occasional reset pulses
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      resetn = ($urandom_range(0, 99) != 0);
      chk_cycle();
      adv();
    end
    resetn = 1;
    idle();
    chk_cycle(); adv();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_forward_pipe.md
# wb_forward_pipe

Back-end write-back pipeline of the CPU: it takes each retiring EX-stage result, carries it through the MEM and WB pipeline registers, and drives the register-file write port. It is the producer side of the ID-stage forwarding path: it generates the EX, MEM and WB forwarding buses, each in the 38-bit `{we, waddr[4:0], result[31:0]}` format the register file consumes. It also raises the load-use stall request to the front end.

## Interface
- DATA_W, 32, data width; the bus formats below assume 32
- REG_AW, 5, register address width; the bus formats below assume 5
- clk  in  1  sole clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX stage holds a real instruction this cycle
- ex_rf_we  in  1  EX instruction writes a register
- ex_rf_waddr  in  5  destination register of the EX instruction
- ex_result  in  32  ALU/address result of the EX instruction
- ex_is_load  in  1  EX instruction is a load; its final value is mem_rdata
- mem_rdata  in  32  load data from data SRAM, valid during the MEM-stage cycle
- stall  in  1  global pipeline stall; hold MEM and WB registers
- flush  in  1  kill the instruction entering MEM (exception/redirect)
- id_raddr1, id_raddr2  in  5 each  source registers of the ID instruction
- ex_to_id_bus  out  38  {we, waddr, result}; combinational from EX inputs
- mem_to_id_bus  out  38  {we, waddr, result}; driven from the MEM register
- wb_to_id_bus  out  38  {we, waddr, result}; driven from the WB register
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- load_use_stall  out  1  ID must hold for one cycle, and a bubble is injected into EX

## Operation
- Effective write enable at every stage: we = valid & rf_we & (waddr != 0). Register 0 never appears as written on any bus or on the write port.
- ex_to_id_bus
  - we = ex_valid & ex_rf_we & ~ex_is_load & (ex_rf_waddr != 0).
  - A load is never forwarded from EX, because its data does not yet exist.
  - result = ex_result.
- MEM register (m_valid, m_we, m_waddr, m_result, m_is_load)
  - On each non-stalled edge it captures the EX fields.
  - m_valid = ex_valid & ~flush.
- mem_to_id_bus
  - we = m_valid & m_we & (m_waddr != 0).
  - result = m_is_load ? mem_rdata : m_result.
- WB register (w_valid, w_we, w_waddr, w_data)
  - On each non-stalled edge it captures the MEM fields, with w_data = the mem_to_id_bus result.
- Write port and WB bus
  - rf_we / rf_waddr / rf_wdata = wb_to_id_bus fields.
  - The write lands in the register array at the end of the WB cycle.
- load_use_stall = ex_valid & ex_is_load & ex_rf_we & (ex_rf_waddr != 0) & ((id_raddr1 == ex_rf_waddr) | (id_raddr2 == ex_rf_waddr)).
  - It is purely combinational, and this block holds no state for it.
  - The front end holds ID and drives ex_valid = 0 in the next cycle.
- Forwarding priority (for consumers): EX over MEM over WB over array. This block guarantees all three buses are simultaneously correct.

## Timing
- Reset
  - Asynchronous on the falling edge of resetn.
  - m_valid, w_valid, all stored we/waddr/data bits, and all bus fields read as 0.
  - rf_we = 0 and load_use_stall = 0 while in reset, because no instruction is valid.
- Latency
  - An instruction in EX at cycle N is in MEM at N+1 and in WB at N+2.
  - Its register-array write commits at the rising edge ending N+2.
  - It appears on ex_to_id_bus at N, on mem_to_id_bus at N+1, and on wb_to_id_bus at N+2.
- stall = 1
  - MEM and WB registers hold, and EX inputs are ignored.
  - rf_we stays asserted if WB is valid. The repeated write of the same data is idempotent by design.
- flush = 1
  - On the next edge m_valid becomes 0, and WB advances normally.
  - flush takes priority over stall for the MEM register only: when both are high, the MEM register is cleared and the WB register holds.
- A load needs exactly one stall cycle. Its data appears on mem_to_id_bus in the cycle the stalled consumer re-reads.
- Back-to-back writes to the same register: each bus reflects only its own stage. Resolution is done by consumer priority.
- resetn asserted mid-pipeline discards all in-flight instructions with no register write.

## Test plan
- Reset: resetn = 0 with garbage on the inputs.
  - Required: all outputs 0 and rf_we = 0.
  - After release, with no valid EX input: rf_we stays 0.
- ALU chain: EX writes r5 = 0x1234 at cycle N.
  - Required: ex_to_id_bus = {1, 5, 0x1234} at N, mem_to_id_bus the same at N+1, rf_we = 1 / rf_waddr = 5 / rf_wdata = 0x1234 at N+2.
- Load-use: a load to r8 is in EX and id_raddr2 = 8.
  - Required: load_use_stall = 1 and ex_to_id_bus.we = 0.
  - Next cycle with mem_rdata = 0xCAFE: mem_to_id_bus = {1, 8, 0xCAFE}.
  - Following cycle: rf_wdata = 0xCAFE.
- r0 writes: EX writes r0 = 0xFFFF.
  - Required: every bus we = 0 and rf_we never asserts.
  - A load to r0 with id_raddr1 = 0: load_use_stall = 0.
- Stall hold: stall = 1 for 3 cycles while WB holds a write r3 = 7.
  - Required: rf_we = 1, rf_waddr = 3, rf_wdata = 7 held constant, and mem_to_id_bus unchanged.
- Flush plus reset: flush with an instruction in EX.
  - Required: the instruction never reaches WB (rf_we = 0 two cycles later).
  - resetn pulsed while MEM and WB are valid: both cleared immediately and no write issued.
